// File: rtl/seg7_pkg.sv
// Shared constants and state type for the 7-segment frame reader.
// Segment codes are active-low, bit 7 is the decimal point.
package seg7_pkg;

   localparam logic [7:0] SEG_H     = 8'h89;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_L     = 8'hC7;
   localparam logic [7:0] SEG_O     = 8'hC0;
   localparam logic [7:0] SEG_FILL  = 8'h08;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [7:0] ASCII_H       = 8'h48;
   localparam logic [7:0] ASCII_E       = 8'h45;
   localparam logic [7:0] ASCII_L       = 8'h4C;
   localparam logic [7:0] ASCII_O       = 8'h4F;
   localparam logic [7:0] ASCII_FILL    = 8'h20;
   localparam logic [7:0] ASCII_BLANK   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   typedef enum logic {
      ST_IDLE,
      ST_EMIT
   } reader_state_t;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational segment-code to ASCII lookup; unknown codes give '?'
// with err set.
module seg7_char_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg,
   output logic [7:0] ascii,
   output logic       err
);

   always_comb begin
      ascii = ASCII_UNKNOWN;
      err   = 1'b1;
      case (seg)
         SEG_H:     begin ascii = ASCII_H;     err = 1'b0; end
         SEG_E:     begin ascii = ASCII_E;     err = 1'b0; end
         SEG_L:     begin ascii = ASCII_L;     err = 1'b0; end
         SEG_O:     begin ascii = ASCII_O;     err = 1'b0; end
         SEG_FILL:  begin ascii = ASCII_FILL;  err = 1'b0; end
         SEG_BLANK: begin ascii = ASCII_BLANK; err = 1'b0; end
         default:   begin ascii = ASCII_UNKNOWN; err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_frame_reader.sv
// Snapshots an active-low 7-segment frame and streams it out as ASCII,
// digit 0 first. Optional saturating error counter: SEG7_READER_ERRCNT_EN.
module seg7_frame_reader
   import seg7_pkg::*;
#(
   parameter int pNO_LED = 8
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [pNO_LED-1:0][7:0]     frame_in,
   input  logic                        frame_valid,
   output logic                        frame_ready,
   output logic [7:0]                  char_out,
   output logic [$clog2(pNO_LED)-1:0]  char_idx,
   output logic                        char_valid,
   input  logic                        char_ready,
   output logic                        char_last,
   output logic                        char_err,
`ifdef SEG7_READER_ERRCNT_EN
   output logic [7:0]                  err_cnt,
`endif
   output logic                        drop
);

   localparam int IDX_W = $clog2(pNO_LED);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pNO_LED - 1);

   reader_state_t           state, state_nxt;
   logic [pNO_LED-1:0][7:0] shadow;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic                    load;
   logic [7:0]              dec_ascii;
   logic                    dec_err;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_valid) begin
               load      = 1'b1;
               idx_nxt   = '0;
               state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (char_ready) begin
               if (idx == LAST_IDX) state_nxt = ST_IDLE;
               else                 idx_nxt   = idx + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= '0;
         shadow <= {pNO_LED{SEG_BLANK}};
         drop   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (load) shadow <= frame_in;
         // any frame offered while emitting, including the final beat, is lost
         drop  <= frame_valid && (state == ST_EMIT);
      end
   end

   seg7_char_decode u_decode (
      .seg   (shadow[idx]),
      .ascii (dec_ascii),
      .err   (dec_err)
   );

   assign frame_ready = (state == ST_IDLE);
   assign char_valid  = (state == ST_EMIT);
   assign char_out    = dec_ascii;
   assign char_idx    = idx;
   assign char_last   = char_valid && (idx == LAST_IDX);
   assign char_err    = char_valid && dec_err;

`ifdef SEG7_READER_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (char_valid && char_ready && char_err && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Scoreboard bench for seg7_frame_reader (8-digit instance plus a 4-digit
// instance); honours SEG7_READER_ERRCNT_EN when defined.
module tb_seg7_frame_reader;

   localparam int N  = 8;
   localparam int N4 = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0][7:0] frame_in = '1;
   logic              frame_valid = 1'b0;
   logic              frame_ready;
   logic [7:0]        char_out;
   logic [2:0]        char_idx;
   logic              char_valid;
   logic              char_ready = 1'b1;
   logic              char_last;
   logic              char_err;
   logic              drop;

   logic [N4-1:0][7:0] frame_in4 = '1;
   logic               frame_valid4 = 1'b0;
   logic               frame_ready4;
   logic [7:0]         char_out4;
   logic [1:0]         char_idx4;
   logic               char_valid4;
   logic               char_ready4 = 1'b1;
   logic               char_last4;
   logic               char_err4;
   logic               drop4;
`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0]         err_cnt;
   logic [7:0]         err_cnt4;
`endif

   seg7_frame_reader #(.pNO_LED(N)) dut (
      .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .char_out(char_out), .char_idx(char_idx),
      .char_valid(char_valid), .char_ready(char_ready), .char_last(char_last),
      .char_err(char_err),
`ifdef SEG7_READER_ERRCNT_EN
      .err_cnt(err_cnt),
`endif
      .drop(drop)
   );

   seg7_frame_reader #(.pNO_LED(N4)) dut4 (
      .clk(clk), .rst(rst), .frame_in(frame_in4), .frame_valid(frame_valid4),
      .frame_ready(frame_ready4), .char_out(char_out4), .char_idx(char_idx4),
      .char_valid(char_valid4), .char_ready(char_ready4), .char_last(char_last4),
      .char_err(char_err4),
`ifdef SEG7_READER_ERRCNT_EN
      .err_cnt(err_cnt4),
`endif
      .drop(drop4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ch;
      int unsigned idx;
      bit          last;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ref_tbl [bit [7:0]];
   int          n_err = 0;
   int          n_chk = 0;
   int          ready_mode = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: digit i of the frame becomes one character, looked up by code
   function automatic void push_frame(input logic [N-1:0][7:0] f);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.err  = !ref_tbl.exists(f[i]);
         e.ch   = e.err ? 8'h3F : ref_tbl[f[i]];
         e.idx  = i;
         e.last = (i == N - 1);
         sb.push_back(e);
      end
   endfunction

   // ready pattern driver
   initial begin
      int unsigned rcnt = 0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: char_ready = 1'b1;
            1: begin char_ready = (rcnt % 3 == 0); rcnt++; end
            default: char_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: compares DUT outputs with the scoreboard every cycle
   initial begin
      bit          exp_drop = 0;
      bit          chk_rst = 0;
      bit          busy;
      int unsigned err_model = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            exp_drop  = 0;
            chk_rst   = 1;
            err_model = 0;
         end else begin
            if (chk_rst) begin
               chk("rst_char_out", char_out, 8'h20);
               chk("rst_char_idx", char_idx, 0);
               chk("rst_char_last", char_last, 0);
               chk("rst_char_err", char_err, 0);
               chk_rst = 0;
            end
            busy = (sb.size() != 0);
            chk("drop", drop, exp_drop);
            chk("frame_ready", frame_ready, !busy);
            chk("char_valid", char_valid, busy);
`ifdef SEG7_READER_ERRCNT_EN
            chk("err_cnt", err_cnt, err_model);
`endif
            exp_drop = frame_valid && busy;
            if (char_valid && busy) begin
               e = sb[0];
               chk("char_out", char_out, e.ch);
               chk("char_idx", char_idx, e.idx);
               chk("char_last", char_last, e.last);
               chk("char_err", char_err, e.err);
               if (char_ready) begin
                  void'(sb.pop_front());
                  if (e.err && err_model < 255) err_model++;
               end
            end
            if (frame_valid && !busy) push_frame(frame_in);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0][7:0] f);
      int t = 0;
      while (!frame_ready && t < 500) begin tick(1); t++; end
      if (!frame_ready) begin
         n_chk++; n_err++;
         $display("FAIL send_timeout: frame_ready=%0b required=1", frame_ready);
      end
      frame_in    = f;
      frame_valid = 1'b1;
      tick(1);
      frame_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      tick(1);
      while (!frame_ready && t < 1000) begin tick(1); t++; end
      if (!frame_ready) begin
         n_chk++; n_err++;
         $display("FAIL idle_timeout: frame_ready=%0b required=1", frame_ready);
      end
   endtask

   task automatic pulse_valid();
      frame_in    = {N{8'h5A}};
      frame_valid = 1'b1;
      tick(1);
      frame_valid = 1'b0;
   endtask

   logic [N-1:0][7:0] hello;
   logic [N-1:0][7:0] f;
   logic [7:0]        pool [6];
   logic [7:0]        oleh [4];

   initial begin
      ref_tbl[8'h89] = 8'h48;
      ref_tbl[8'h86] = 8'h45;
      ref_tbl[8'hC7] = 8'h4C;
      ref_tbl[8'hC0] = 8'h4F;
      ref_tbl[8'h08] = 8'h20;
      ref_tbl[8'hFF] = 8'h20;
      pool = '{8'h89, 8'h86, 8'hC7, 8'hC0, 8'h08, 8'hFF};
      oleh = '{8'h4F, 8'h4C, 8'h45, 8'h48};
      hello = {8'h08, 8'h08, 8'h08, 8'hC0, 8'hC7, 8'hC7, 8'h86, 8'h89};

      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);

      ready_mode = 0;
      send(hello); wait_idle();

      ready_mode = 1;
      send(hello); wait_idle();

      ready_mode = 0;
      f = hello; f[3] = 8'h5A;
      send(f); wait_idle();
`ifdef SEG7_READER_ERRCNT_EN
      chk("err_cnt_one", err_cnt, 1);
`endif

      // offers during the frame and on its final beat must both be dropped
      send(hello);
      tick(1);
      pulse_valid();
      tick(5);
      pulse_valid();
      wait_idle();

      // reset while idx 4 is on the output
      send(hello);
      tick(4);
      chk("pre_rst_idx", char_idx, 4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      send(hello); wait_idle();

      ready_mode = 2;
      repeat (20) begin
         for (int i = 0; i < N; i++)
            f[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
         send(f);
         if ($urandom_range(0, 1) == 1) begin
            tick($urandom_range(0, 5));
            pulse_valid();
         end
         wait_idle();
      end

`ifdef SEG7_READER_ERRCNT_EN
      ready_mode = 0;
      repeat (40) send({N{8'h5A}});
      wait_idle();
      chk("err_cnt_sat", err_cnt, 8'hFF);
`endif

      // 4-digit instance: C0,C7,86,89 reads back as "OLEH"
      frame_in4    = {8'h89, 8'h86, 8'hC7, 8'hC0};
      frame_valid4 = 1'b1;
      tick(1);
      frame_valid4 = 1'b0;
      for (int i = 0; i < N4; i++) begin
         @(negedge clk);
         chk("n4_valid", char_valid4, 1);
         chk("n4_char", char_out4, oleh[i]);
         chk("n4_idx", char_idx4, i);
         chk("n4_last", char_last4, (i == N4 - 1));
      end
      @(negedge clk);
      chk("n4_ready", frame_ready4, 1);
      chk("n4_valid_end", char_valid4, 0);

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/seg7_frame_reader.md
# seg7_frame_reader

Consumes the 8-digit active-low 7-segment frame that the scrolling display block drives onto its LED bus. It snapshots one frame on a valid/ready handshake and decodes each segment byte back to ASCII. It then streams the characters out one per handshake, digit 0 first, with index, last and error tags. It sits on the monitor/loopback side of the display path, so the display contents can be checked or forwarded as text.

## Interface
- pNO_LED, 8: digits per frame; must be ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- frame_in  in  [pNO_LED-1:0][7:0]  segment codes, digit 0 in [0].
- frame_valid  in  1  frame_in is valid this cycle.
- frame_ready  out  1  block is idle and can accept a frame.
- char_out  out  8  decoded ASCII character.
- char_idx  out  $clog2(pNO_LED)  digit index of char_out.
- char_valid  out  1  char_out, char_idx, char_last and char_err are valid.
- char_ready  in  1  downstream accepts the character.
- char_last  out  1  char_out is the last digit (pNO_LED-1).
- char_err  out  1  segment code was not in the decode table.
- drop  out  1  one-cycle pulse: frame_valid arrived while busy.

## Operation
- FSM has two states, IDLE and EMIT. frame_ready = (state==IDLE).
- IDLE: when frame_valid is high, latch frame_in into the shadow register, set idx=0 and go to EMIT.
- EMIT: char_valid=1. Outputs are char_out=decode(shadow[idx]), char_idx=idx and char_last=(idx==pNO_LED-1).
  - A handshake (char_valid && char_ready) with char_last=0 increments idx.
  - A handshake with char_last=1 returns the FSM to IDLE.
- Without a handshake, all char_* outputs hold stable. Do not change them while char_valid && !char_ready.
- Decode table:
  - 0x89 → 'H' (0x48)
  - 0x86 → 'E' (0x45)
  - 0xC7 → 'L' (0x4C)
  - 0xC0 → 'O' (0x4F)
  - 0x08 → ' ' (0x20, filler)
  - 0xFF → ' ' (blank)
  - any other code → '?' (0x3F) with char_err=1.
- frame_valid while in EMIT: the frame is ignored, the shadow register is untouched, and drop pulses high in the next cycle.
- frame_valid in the cycle of the final handshake is also dropped. No same-cycle reaccept.
- idx never wraps past pNO_LED-1. char_last governs the return to IDLE.

## Timing
- Reset values: state=IDLE, frame_ready=1, char_valid=0, char_out=0x20, char_idx=0, char_last=0, char_err=0, drop=0, shadow=all 0xFF.
- All outputs are registered or decoded from registered state only. No combinational path from input to output except none on frame_ready.
- Frame accepted at edge N: char_valid=1 and idx=0 in cycle N+1.
- With char_ready held high, characters occupy cycles N+1..N+pNO_LED. frame_ready returns in cycle N+pNO_LED+1.
- Throughput is one frame per pNO_LED+1 cycles.
- rst asserted mid-EMIT: at the next edge all state takes reset values. Any partial frame is discarded, and no char_last is emitted for it.

## Configuration
- SEG7_READER_ERRCNT_EN defined: adds output err_cnt (8 bits).
  - Increments on each handshake with char_err=1 and saturates at 0xFF.
  - Cleared only by rst.
- Not defined: the err_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- seg7_pkg holds:
  - segment-code constants (SEG_H, SEG_E, SEG_L, SEG_O, SEG_FILL, SEG_BLANK)
  - matching ASCII constants and ASCII_UNKNOWN
  - the reader state enum.
- Sub-module seg7_char_decode is a combinational lookup: seg[7:0] → ascii[7:0], err. It is instantiated once on shadow[idx].

## Test plan
- Reset, then a frame with digits 0..7 = 89,86,C7,C7,C0,08,08,08 and char_ready=1 → "HELLO   " on idx 0..7 in consecutive cycles, char_last only at idx 7, char_err always 0, frame_ready back after 9 cycles.
- Same frame with char_ready toggling 1,0,0,1… → no character lost or duplicated, and outputs stable during every stall.
- Frame containing 0x5A at digit 3 → char_out=0x3F with char_err=1 at idx 3 only. With SEG7_READER_ERRCNT_EN, err_cnt=1 afterwards; after 300 such errors err_cnt=0xFF.
- Second frame_valid at cycles N+2 and N+8 (final handshake) → drop pulses once for each, and the first frame's output is unchanged.
- rst asserted at idx 4 → next cycle all outputs at reset values. A new frame is then accepted and starts from idx 0.
- pNO_LED=4 with frame C0,C7,86,89 → "OLEH", char_last at idx 3.
